breath_led_array: RTL and testbench

Multi-channel breathing-LED driver and the successor to the single-channel breathing LED. One shared PWM counter defines the PWM frame. Each channel has its own triangular duty ramp with a fixed phase offset. A per-channel mode selects off, constant on, breathing, or blink. It sits directly behind the board LED pins and is driven by the board clock domain and run-time control registers.

---
 rtl/breath_pkg.sv | 17 +
 rtl/breath_led_array_ch.sv | 82 ++++++++
 rtl/breath_led_array.sv | 64 ++++++
 tb/tb_breath_led_array.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/breath_pkg.sv
// Shared definitions for the multi-channel breathing LED driver:
// per-channel mode encoding and the reset-duty phase offset helper.
package breath_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF    = 2'b00;
    localparam mode_t MODE_ON     = 2'b01;
    localparam mode_t MODE_BREATH = 2'b10;
    localparam mode_t MODE_BLINK  = 2'b11;

    // Spreads the channels evenly across the duty range so their ramps stay phase-shifted.
    function automatic int resetDuty(input int idx, input int pwmMax, input int numCh);
        return (idx * pwmMax) / numCh;
    endfunction

endpackage

// File: rtl/breath_led_array_ch.sv
// One LED channel: triangular duty ramp, direction flag, peak pulse and the
// registered LED drive derived from the shared PWM counter.
module breath_ch
    import breath_pkg::*;
#(
    parameter int CW         = 12,
    parameter int PWM_MAX    = 2400,
    parameter int RESET_DUTY = 0,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_tick_i,
    input  logic [CW-1:0] pwm_cnt_i,
    input  mode_t         mode_i,
    input  logic          hold_i,
    output logic          led_o,
    output logic          peak_o
);

    localparam logic [CW-1:0] DUTY_MAX  = CW'(PWM_MAX - 1);
    localparam logic [CW-1:0] DUTY_INIT = CW'(RESET_DUTY);

    logic [CW-1:0] duty_q, duty_d;
    logic          dir_q, dir_d;
    logic          peak_q, peak_d;
    logic          led_q, led_d;
    logic          lit;

    // Saturating ramp: each end is held for one extra frame while the direction turns around.
    always_comb begin
        duty_d = duty_q;
        dir_d  = dir_q;
        peak_d = 1'b0;
        if (frame_tick_i && !hold_i) begin
            if (!dir_q) begin
                if (duty_q >= DUTY_MAX) begin
                    dir_d  = 1'b1;
                    peak_d = 1'b1;
                end else begin
                    duty_d = duty_q + 1'b1;
                end
            end else begin
                if (duty_q == '0) begin
                    dir_d = 1'b0;
                end else begin
                    duty_d = duty_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        lit = 1'b0;
        unique case (mode_i)
            MODE_OFF:    lit = 1'b0;
            MODE_ON:     lit = 1'b1;
            MODE_BREATH: lit = (pwm_cnt_i < duty_q);
            MODE_BLINK:  lit = !dir_q;
            default:     lit = 1'b0;
        endcase
        led_d = lit ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= DUTY_INIT;
            dir_q  <= 1'b0;
            peak_q <= 1'b0;
            led_q  <= ACTIVE_LOW;
        end else begin
            duty_q <= duty_d;
            dir_q  <= dir_d;
            peak_q <= peak_d;
            led_q  <= led_d;
        end
    end

    assign led_o  = led_q;
    assign peak_o = peak_q;

endmodule

// File: rtl/breath_led_array.sv
// Multi-channel breathing LED driver: one shared PWM frame counter feeding
// CH phase-offset breath_ch channels.
module breath_led_array
    import breath_pkg::*;
#(
    parameter int CH         = 4,
    parameter int PWM_MAX    = 2400,
    parameter int CW         = 12,
    parameter int ACTIVE_LOW = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*CH-1:0] mode,
    input  logic            hold,
    output logic [CH-1:0]   led,
    output logic [CH-1:0]   peak,
    output logic            frame_tick
);

    if (CW < $clog2(PWM_MAX) || PWM_MAX < 2 || CH < 1 || CH > PWM_MAX) begin : genBadParam
        $error("breath_led_array: illegal parameters CH=%0d PWM_MAX=%0d CW=%0d", CH, PWM_MAX, CW);
    end

    localparam logic [CW-1:0] PWM_LAST = CW'(PWM_MAX - 1);

    logic [CW-1:0] pwmCnt_q, pwmCnt_d;

    // A held wrap cycle produces no tick, so duty updates are suppressed along with the counter.
    assign frame_tick = (pwmCnt_q == PWM_LAST) && !hold;

    always_comb begin
        pwmCnt_d = pwmCnt_q;
        if (!hold) begin
            pwmCnt_d = (pwmCnt_q == PWM_LAST) ? '0 : pwmCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwmCnt_q <= '0;
        end else begin
            pwmCnt_q <= pwmCnt_d;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : genCh
        breath_ch #(
            .CW         (CW),
            .PWM_MAX    (PWM_MAX),
            .RESET_DUTY (resetDuty(i, PWM_MAX, CH)),
            .ACTIVE_LOW (ACTIVE_LOW != 0)
        ) uCh (
            .clk          (clk),
            .rst          (rst),
            .frame_tick_i (frame_tick),
            .pwm_cnt_i    (pwmCnt_q),
            .mode_i       (mode[2*i +: 2]),
            .hold_i       (hold),
            .led_o        (led[i]),
            .peak_o       (peak[i])
        );
    end

endmodule

// File: tb/tb_breath_led_array.sv
// Self-checking bench for breath_led_array (CH=4, PWM_MAX=8, CW=4, active-low):
// a behavioural model feeds a scoreboard queue, plus directed ramp/mode/hold/reset checks.
module tb_breath_led_array;
    import breath_pkg::*;

    localparam int CH      = 4;
    localparam int PWM_MAX = 8;
    localparam int CW      = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            hold;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   led;
    logic [CH-1:0]   peak;
    logic            frame_tick;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [CH-1:0] led;
        logic [CH-1:0] peak;
    } exp_t;

    exp_t expQ[$];
    exp_t mExp;
    exp_t cExp;
    int   mP = 0;
    int   mD[CH] = '{0, 2, 4, 6};
    logic mDir[CH] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic mFt;
    logic mLit;

    breath_led_array #(
        .CH         (CH),
        .PWM_MAX    (PWM_MAX),
        .CW         (CW),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .hold       (hold),
        .led        (led),
        .peak       (peak),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2*CH-1:0] m, input logic h, input logic r);
        mode = m;
        hold = h;
        rst  = r;
    endtask

    task automatic waitCycle();
        @(negedge clk);
        #1;
    endtask

    // Behavioural model: predicts what the DUT registers at each edge and queues it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mP = 0;
            for (int i = 0; i < CH; i++) begin
                mD[i]   = i * PWM_MAX / CH;
                mDir[i] = 1'b0;
            end
            expQ.delete();
        end else begin
            mFt = (mP == PWM_MAX - 1) && !hold;
            for (int i = 0; i < CH; i++) begin
                case (mode[2*i +: 2])
                    MODE_OFF:    mLit = 1'b0;
                    MODE_ON:     mLit = 1'b1;
                    MODE_BREATH: mLit = (mP < mD[i]);
                    default:     mLit = !mDir[i];
                endcase
                mExp.led[i]  = !mLit;
                mExp.peak[i] = mFt && !mDir[i] && (mD[i] == PWM_MAX - 1);
            end
            if (!hold) mP = (mP == PWM_MAX - 1) ? 0 : mP + 1;
            if (mFt) begin
                for (int i = 0; i < CH; i++) begin
                    if (!mDir[i]) begin
                        if (mD[i] == PWM_MAX - 1) mDir[i] = 1'b1;
                        else mD[i] = mD[i] + 1;
                    end else begin
                        if (mD[i] == 0) mDir[i] = 1'b0;
                        else mD[i] = mD[i] - 1;
                    end
                end
            end
            expQ.push_back(mExp);
        end
    end

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            cExp = expQ.pop_front();
            checkOutput("sb_led", led, cExp.led);
            checkOutput("sb_peak", peak, cExp.peak);
            checkOutput("sb_frame_tick", frame_tick, (mP == PWM_MAX - 1) && !hold);
        end else if (rst) begin
            checkOutput("sb_rst_led", led, 4'hF);
            checkOutput("sb_rst_peak", peak, 4'h0);
        end
    end

    int dutySeq[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 0};
    int dark[16];
    int peak0Cnt, peak0At, peak1At;
    int topDuty, topDir;
    int onCnt0, litCnt1;
    int pSnap, dSnap, ftCnt, pkCnt;
    int found, lit2;

    initial begin
        applyStimulus(8'hAA, 1'b0, 1'b1);
        repeat (3) waitCycle();
        checkOutput("reset_led", led, 4'hF);
        checkOutput("reset_peak", peak, 4'h0);
        checkOutput("reset_p", dut.pwmCnt_q, 0);

        // All channels breathing over one full 128-clock ramp.
        applyStimulus(8'hAA, 1'b0, 1'b0);
        for (int f = 0; f < 16; f++) dark[f] = 0;
        peak0Cnt = 0; peak0At = -1; peak1At = -1; topDuty = -1; topDir = -1;
        for (int k = 0; k < 128; k++) begin
            waitCycle();
            if (led[0] == 1'b0) dark[k / 8]++;
            if (peak[0]) begin
                peak0Cnt++;
                peak0At = k;
                topDuty = int'(dut.genCh[0].uCh.duty_q);
                topDir  = int'(dut.genCh[0].uCh.dir_q);
            end
            if (peak[1] && peak1At < 0) peak1At = k;
        end
        for (int f = 0; f < 16; f++) checkOutput($sformatf("breath_duty_frame%0d", f), dark[f], dutySeq[f]);
        checkOutput("peak0_count", peak0Cnt, 1);
        checkOutput("peak0_time", peak0At, 63);
        checkOutput("peak1_lead", peak0At - peak1At, 16);
        checkOutput("top_duty_held", topDuty, 7);
        checkOutput("top_dir_flipped", topDir, 1);
        checkOutput("bottom_duty_held", dut.genCh[0].uCh.duty_q, 0);
        checkOutput("bottom_dir_flipped", dut.genCh[0].uCh.dir_q, 0);

        // Mixed modes: ch3 BLINK, ch2 BREATH, ch1 ON, ch0 OFF.
        applyStimulus(8'b11_10_01_00, 1'b0, 1'b0);
        onCnt0 = 0; litCnt1 = 0;
        for (int k = 0; k < 40; k++) begin
            waitCycle();
            if (led[0] === 1'b1) onCnt0++;
            if (led[1] === 1'b0) litCnt1++;
        end
        checkOutput("mode_off_dark", onCnt0, 40);
        checkOutput("mode_on_lit", litCnt1, 40);

        // Hold mid-ramp for 50 clocks.
        applyStimulus(8'hAA, 1'b0, 1'b0);
        repeat (13) waitCycle();
        applyStimulus(8'hAA, 1'b1, 1'b0);
        pSnap = mP; dSnap = mD[0]; ftCnt = 0; pkCnt = 0;
        for (int k = 0; k < 50; k++) begin
            waitCycle();
            if (frame_tick) ftCnt++;
            if (peak != 4'h0) pkCnt++;
        end
        checkOutput("hold_p_frozen", dut.pwmCnt_q, pSnap);
        checkOutput("hold_d_frozen", dut.genCh[0].uCh.duty_q, dSnap);
        checkOutput("hold_no_tick", ftCnt, 0);
        checkOutput("hold_no_peak", pkCnt, 0);
        applyStimulus(8'hAA, 1'b0, 1'b0);
        waitCycle();
        checkOutput("hold_resume_p", dut.pwmCnt_q, (pSnap + 1) % PWM_MAX);

        // ch2 held ON until its duty reaches 5 at a frame start, then switched to BREATH.
        applyStimulus(8'b10_01_10_10, 1'b0, 1'b0);
        found = 0;
        for (int k = 0; k < 400 && found == 0; k++) begin
            waitCycle();
            if (mP == 0 && mD[2] == 5) found = 1;
        end
        checkOutput("ch2_wait_d5", found, 1);
        applyStimulus(8'hAA, 1'b0, 1'b0);
        lit2 = 0;
        for (int k = 0; k < PWM_MAX; k++) begin
            waitCycle();
            if (led[2] == 1'b0) lit2++;
        end
        checkOutput("ch2_switch_lit", lit2, 5);

        // Asynchronous reset in the middle of a cycle.
        repeat (3) waitCycle();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_led", led, 4'hF);
        checkOutput("async_rst_peak", peak, 4'h0);
        checkOutput("async_rst_p", dut.pwmCnt_q, 0);
        checkOutput("async_rst_d0", dut.genCh[0].uCh.duty_q, 0);
        checkOutput("async_rst_d1", dut.genCh[1].uCh.duty_q, 2);
        checkOutput("async_rst_d2", dut.genCh[2].uCh.duty_q, 4);
        checkOutput("async_rst_d3", dut.genCh[3].uCh.duty_q, 6);
        checkOutput("async_rst_dir3", dut.genCh[3].uCh.dir_q, 0);
        repeat (2) waitCycle();
        applyStimulus(8'hAA, 1'b0, 1'b0);
        repeat (20) waitCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
